// File: rtl/openram_testchip_pkg.sv
// OpenRAM test-chip shared types: packet layout, select codes, FSM states.
// Optional 64-bit SRAM5 is enabled with the SRAM5_EN macro.
package openram_testchip_pkg;

  localparam int PKT_W  = 112;
  localparam int DATA_W = 32;

  // Field order matches the packet bit positions, MSB first
  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr0;
    logic [31:0] din0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [15:0] addr1;
    logic [31:0] din1;
    logic        csb1;
    logic        web1;
    logic [3:0]  wmask1;
  } pkt_t;

  localparam logic [3:0] SEL_SRAM0 = 4'd0;
  localparam logic [3:0] SEL_SRAM1 = 4'd1;
  localparam logic [3:0] SEL_SRAM2 = 4'd2;
  localparam logic [3:0] SEL_SRAM3 = 4'd3;
  localparam logic [3:0] SEL_SRAM4 = 4'd4;
  localparam logic [3:0] SEL_SRAM5 = 4'd5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  localparam logic [54:0] DUAL_OFF = {2'b11, 44'd0, 1'b1, 8'd0};

  function automatic logic [54:0] dual_conn(pkt_t p);
    return {p.csb0, p.web0, p.wmask0, p.addr0[7:0],
            p.din0, p.csb1, p.addr1[7:0]};
  endfunction

endpackage

// File: rtl/openram_testchip_ctrl_if.sv
// Host-side bundle: LA/GPIO packet load, issue, and result readout.
interface openram_testchip_ctrl_if;
  import openram_testchip_pkg::*;

  logic              in_select;
  logic              la_in_load;
  logic              gpio_in_scan;
  logic              la_sram_load;
  logic              gpio_sram_load;
  logic              gpio_out_scan;
  logic              gpio_bit;
  logic [PKT_W-1:0]  la_bits;
  logic [DATA_W-1:0] la_data0;
  logic [DATA_W-1:0] la_data1;
  logic              gpio_data0;
  logic              gpio_data1;

  modport master (
    output in_select, la_in_load, gpio_in_scan,
    output la_sram_load, gpio_sram_load, gpio_out_scan,
    output gpio_bit, la_bits,
    input  la_data0, la_data1, gpio_data0, gpio_data1
  );

  modport slave (
    input  in_select, la_in_load, gpio_in_scan,
    input  la_sram_load, gpio_sram_load, gpio_out_scan,
    input  gpio_bit, la_bits,
    output la_data0, la_data1, gpio_data0, gpio_data1
  );

endinterface

// File: rtl/openram_testchip_outscan.sv
// Result word shift copy: load wins over shift, zeros fill from the LSB.
module openram_testchip_outscan
  import openram_testchip_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              msb
);

  logic [DATA_W-1:0] q;

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= {q[DATA_W-2:0], 1'b0};
  end

  assign msb = q[DATA_W-1];

endmodule

// File: rtl/openram_testchip_ctrl.sv
// OpenRAM test-chip controller: packet capture, one-shot SRAM access, readout.
// Define SRAM5_EN to add the 64-bit SRAM5 port pair (sel=5).
module openram_testchip_ctrl
  import openram_testchip_pkg::*;
(
  input  logic              la_clk,
  input  logic              reset,
  openram_testchip_ctrl_if.slave host,
  input  logic [DATA_W-1:0] sram0_rw_in,
  input  logic [DATA_W-1:0] sram0_ro_in,
  input  logic [DATA_W-1:0] sram1_rw_in,
  input  logic [DATA_W-1:0] sram1_ro_in,
  input  logic [DATA_W-1:0] sram2_rw_in,
  input  logic [DATA_W-1:0] sram3_rw_in,
  input  logic [DATA_W-1:0] sram4_rw_in,
  output logic [54:0]       sram0_connections,
  output logic [54:0]       sram1_connections,
  output logic [47:0]       sram2_connections,
  output logic [45:0]       sram3_connections,
  output logic [46:0]       sram4_connections
`ifdef SRAM5_EN
  ,
  input  logic [63:0]       sram5_rw_in,
  output logic [82:0]       sram5_connections
`endif
);

  logic [PKT_W-1:0]  pkt_q;
  pkt_t              p;
  logic [1:0]        state;
  logic [3:0]        sel_q;
  logic              issue;
  logic              start;
  logic              capture;
  logic [DATA_W-1:0] cap0;
  logic [DATA_W-1:0] cap1;

  assign p       = pkt_t'(pkt_q);
  assign issue   = host.in_select ? host.gpio_sram_load
                                  : host.la_sram_load;
  assign start   = (state == ST_IDLE) && issue;
  assign capture = (state == ST_CAPTURE);

  always_ff @(posedge la_clk) begin
    if (reset)
      pkt_q <= '0;
    else if (!host.in_select && host.la_in_load)
      pkt_q <= host.la_bits;
    else if (host.in_select && host.gpio_in_scan)
      pkt_q <= {pkt_q[PKT_W-2:0], host.gpio_bit};
  end

  always_ff @(posedge la_clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sel_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (issue) begin
          state <= ST_ISSUE;
          sel_q <= p.sel;
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT:  state <= ST_CAPTURE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Pins idle every cycle except the single one after an accepted issue
  always_ff @(posedge la_clk) begin
    sram0_connections <= DUAL_OFF;
    sram1_connections <= DUAL_OFF;
    sram2_connections <= {2'b11, 46'd0};
    sram3_connections <= {2'b11, 44'd0};
    sram4_connections <= {2'b11, 45'd0};
`ifdef SRAM5_EN
    sram5_connections <= {2'b11, 81'd0};
`endif
    if (!reset && start) begin
      case (p.sel)
        SEL_SRAM0: sram0_connections <= dual_conn(p);
        SEL_SRAM1: sram1_connections <= dual_conn(p);
        SEL_SRAM2: sram2_connections <=
          {p.csb0, p.web0, p.wmask0, p.addr0[9:0], p.din0};
        SEL_SRAM3: sram3_connections <=
          {p.csb0, p.web0, p.wmask0, p.addr0[7:0], p.din0};
        SEL_SRAM4: sram4_connections <=
          {p.csb0, p.web0, p.wmask0, p.addr0[8:0], p.din0};
`ifdef SRAM5_EN
        SEL_SRAM5: sram5_connections <=
          {p.csb0, p.web0, p.wmask1, p.wmask0,
           p.addr0[8:0], p.din1, p.din0};
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    cap0 = '0;
    cap1 = '0;
    case (sel_q)
      SEL_SRAM0: begin cap0 = sram0_rw_in; cap1 = sram0_ro_in; end
      SEL_SRAM1: begin cap0 = sram1_rw_in; cap1 = sram1_ro_in; end
      SEL_SRAM2: cap0 = sram2_rw_in;
      SEL_SRAM3: cap0 = sram3_rw_in;
      SEL_SRAM4: cap0 = sram4_rw_in;
`ifdef SRAM5_EN
      SEL_SRAM5: begin
        cap0 = sram5_rw_in[31:0];
        cap1 = sram5_rw_in[63:32];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge la_clk) begin
    if (reset) begin
      host.la_data0 <= '0;
      host.la_data1 <= '0;
    end else if (capture) begin
      host.la_data0 <= cap0;
      host.la_data1 <= cap1;
    end
  end

  openram_testchip_outscan u_scan0 (
    .clk   (la_clk),
    .reset (reset),
    .load  (capture),
    .shift (host.gpio_out_scan),
    .d     (cap0),
    .msb   (host.gpio_data0)
  );

  openram_testchip_outscan u_scan1 (
    .clk   (la_clk),
    .reset (reset),
    .load  (capture),
    .shift (host.gpio_out_scan),
    .d     (cap1),
    .msb   (host.gpio_data1)
  );

endmodule

// File: tb/tb_openram_testchip_ctrl.sv
// Bench for openram_testchip_ctrl: SRAM macro models plus a memory-level
// reference of what each packet should read back.
module tb_openram_testchip_ctrl;
  import openram_testchip_pkg::*;

  logic la_clk = 1'b0;
  logic reset;
  always #5 la_clk = ~la_clk;

  openram_testchip_ctrl_if host ();

  logic [31:0] d0rw = '0, d0ro = '0, d1rw = '0, d1ro = '0;
  logic [31:0] d2 = '0, d3 = '0, d4 = '0;
  logic [54:0] c0, c1;
  logic [47:0] c2;
  logic [45:0] c3;
  logic [46:0] c4;
`ifdef SRAM5_EN
  logic [82:0] c5;
`endif

  openram_testchip_ctrl dut (
    .la_clk            (la_clk),
    .reset             (reset),
    .host              (host),
    .sram0_rw_in       (d0rw),
    .sram0_ro_in       (d0ro),
    .sram1_rw_in       (d1rw),
    .sram1_ro_in       (d1ro),
    .sram2_rw_in       (d2),
    .sram3_rw_in       (d3),
    .sram4_rw_in       (d4),
    .sram0_connections (c0),
    .sram1_connections (c1),
    .sram2_connections (c2),
    .sram3_connections (c3),
    .sram4_connections (c4)
`ifdef SRAM5_EN
    ,
    .sram5_rw_in       (64'd0),
    .sram5_connections (c5)
`endif
  );

  // Macro models: sample pins on the clock edge, hold dout between reads
  logic [31:0] m0 [256]  = '{default: '0};
  logic [31:0] m1 [256]  = '{default: '0};
  logic [31:0] m2 [1024] = '{default: '0};
  logic [31:0] m3 [256]  = '{default: '0};
  logic [31:0] m4 [512]  = '{default: '0};

  function automatic logic [31:0] wmerge(logic [31:0] o, logic [31:0] d,
                                         logic [3:0] wm);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge la_clk) begin
    if (!c0[54]) begin
      if (!c0[53]) m0[c0[48:41]] <= wmerge(m0[c0[48:41]], c0[40:9], c0[52:49]);
      else d0rw <= m0[c0[48:41]];
    end
    if (!c0[8]) d0ro <= m0[c0[7:0]];
    if (!c1[54]) begin
      if (!c1[53]) m1[c1[48:41]] <= wmerge(m1[c1[48:41]], c1[40:9], c1[52:49]);
      else d1rw <= m1[c1[48:41]];
    end
    if (!c1[8]) d1ro <= m1[c1[7:0]];
    if (!c2[47]) begin
      if (!c2[46]) m2[c2[41:32]] <= wmerge(m2[c2[41:32]], c2[31:0], c2[45:42]);
      else d2 <= m2[c2[41:32]];
    end
    if (!c3[45]) begin
      if (!c3[44]) m3[c3[39:32]] <= wmerge(m3[c3[39:32]], c3[31:0], c3[43:40]);
      else d3 <= m3[c3[39:32]];
    end
    if (!c4[46]) begin
      if (!c4[45]) m4[c4[40:32]] <= wmerge(m4[c4[40:32]], c4[31:0], c4[44:41]);
      else d4 <= m4[c4[40:32]];
    end
  end

  // Reference: word contents of each SRAM, indexed by select code
  logic [31:0] ref_mem [5][1024];

  int tests = 0;
  int fails = 0;

  logic [3:0]  f_sel, f_wm0, f_wm1;
  logic [15:0] f_a0, f_a1;
  logic [31:0] f_din0, f_din1;
  logic        f_csb0, f_web0, f_csb1, f_web1;

  function automatic logic [111:0] packet();
    return {f_sel, f_a0, f_din0, f_csb0, f_web0, f_wm0,
            f_a1, f_din1, f_csb1, f_web1, f_wm1};
  endfunction

  function automatic int depth(input logic [3:0] s);
    case (s)
      4'd2:    return 1024;
      4'd4:    return 512;
      default: return 256;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge la_clk);
    #1;
  endtask

  task automatic set_pkt(input logic [3:0] s, input logic [15:0] a0,
                         input logic [31:0] din, input logic csb0,
                         input logic web0, input logic [3:0] wm,
                         input logic [15:0] a1, input logic csb1);
    f_sel = s; f_a0 = a0; f_din0 = din; f_csb0 = csb0; f_web0 = web0;
    f_wm0 = wm; f_a1 = a1; f_csb1 = csb1;
    f_din1 = $urandom; f_web1 = 1'($urandom); f_wm1 = 4'($urandom);
  endtask

  task automatic check_conns(input string tag, input bit on);
    logic [54:0] e0, e1;
    logic [47:0] e2;
    logic [45:0] e3;
    logic [46:0] e4;
    e0 = {2'b11, 44'd0, 1'b1, 8'd0};
    e1 = e0;
    e2 = {2'b11, 46'd0};
    e3 = {2'b11, 44'd0};
    e4 = {2'b11, 45'd0};
    if (on) begin
      case (f_sel)
        4'd0: e0 = {f_csb0, f_web0, f_wm0, f_a0[7:0], f_din0, f_csb1, f_a1[7:0]};
        4'd1: e1 = {f_csb0, f_web0, f_wm0, f_a0[7:0], f_din0, f_csb1, f_a1[7:0]};
        4'd2: e2 = {f_csb0, f_web0, f_wm0, f_a0[9:0], f_din0};
        4'd3: e3 = {f_csb0, f_web0, f_wm0, f_a0[7:0], f_din0};
        4'd4: e4 = {f_csb0, f_web0, f_wm0, f_a0[8:0], f_din0};
        default: ;
      endcase
    end
    chk({tag, ".c0"}, c0, e0);
    chk({tag, ".c1"}, c1, e1);
    chk({tag, ".c2"}, c2, e2);
    chk({tag, ".c3"}, c3, e3);
    chk({tag, ".c4"}, c4, e4);
  endtask

  task automatic load_la();
    host.in_select = 1'b0;
    host.la_bits = packet();
    host.la_in_load = 1'b1;
    tick();
    host.la_in_load = 1'b0;
    host.gpio_bit = 1'b1;
    host.gpio_in_scan = 1'b1;
    tick();
    host.gpio_in_scan = 1'b0;
  endtask

  task automatic load_gpio();
    logic [111:0] pk;
    pk = packet();
    host.in_select = 1'b1;
    host.la_bits = ~pk;
    host.la_in_load = 1'b1;
    for (int i = 111; i >= 0; i--) begin
      host.gpio_bit = pk[i];
      host.gpio_in_scan = 1'b1;
      tick();
    end
    host.gpio_in_scan = 1'b0;
    host.la_in_load = 1'b0;
  endtask

  task automatic run_access(input string tag);
    logic [31:0] x0, x1;
    bit k0, k1, rd0, wr0;
    int dep;
    rd0 = !f_csb0 && f_web0;
    wr0 = !f_csb0 && !f_web0;
    k0 = 0; k1 = 0; x0 = '0; x1 = '0;
    if (f_sel > 4'd4) begin
      k0 = 1; k1 = 1;
    end else begin
      dep = depth(f_sel);
      if (rd0) begin k0 = 1; x0 = ref_mem[f_sel][f_a0 % dep]; end
      if (f_sel >= 4'd2) k1 = 1;
      else if (!f_csb1 && !wr0) begin
        k1 = 1;
        x1 = ref_mem[f_sel][f_a1 % dep];
      end
      if (wr0)
        for (int b = 0; b < 4; b++)
          if (f_wm0[b]) ref_mem[f_sel][f_a0 % dep][8*b +: 8] = f_din0[8*b +: 8];
    end
    if (host.in_select) host.gpio_sram_load = 1'b1;
    else host.la_sram_load = 1'b1;
    tick();
    host.gpio_sram_load = 1'b0;
    host.la_sram_load = 1'b0;
    check_conns({tag, ".issue"}, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_conns({tag, ".quiet"}, 0);
    end
    if (k0) begin
      chk({tag, ".la0"}, host.la_data0, x0);
      chk({tag, ".gp0"}, host.gpio_data0, x0[31]);
    end
    if (k1) begin
      chk({tag, ".la1"}, host.la_data1, x1);
      chk({tag, ".gp1"}, host.gpio_data1, x1[31]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 1024; a++) ref_mem[s][a] = '0;
    reset = 1'b1;
    host.in_select = 0; host.la_in_load = 0; host.gpio_in_scan = 0;
    host.la_sram_load = 0; host.gpio_sram_load = 0;
    host.gpio_out_scan = 0; host.gpio_bit = 0; host.la_bits = '0;
    tick();
    tick();
    check_conns("reset", 0);
    chk("reset.la0", host.la_data0, 32'h0);
    chk("reset.la1", host.la_data1, 32'h0);
    chk("reset.gp0", host.gpio_data0, 1'b0);
    chk("reset.gp1", host.gpio_data1, 1'b0);
    reset = 1'b0;
    tick();

    set_pkt(4'd0, 16'h0001, 32'h1, 1'b0, 1'b0, 4'hF, 16'h0, 1'b1);
    load_la();
    run_access("la_wr");
    set_pkt(4'd0, 16'h0001, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0001, 1'b0);
    load_la();
    run_access("la_rd");
    chk("la_rd.word0", host.la_data0, 32'h1);
    chk("la_rd.word1", host.la_data1, 32'h1);

    set_pkt(4'd0, 16'h0001, 32'h1, 1'b0, 1'b0, 4'hF, 16'h0, 1'b1);
    load_gpio();
    run_access("gp_wr");
    set_pkt(4'd0, 16'h0001, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0, 1'b1);
    load_gpio();
    run_access("gp_rd");
    chk("gp_rd.word0", host.la_data0, 32'h1);

    set_pkt(4'd2, 16'h0401, 32'hA5A5_1234, 1'b0, 1'b0, 4'hF, 16'h0, 1'b1);
    load_la();
    run_access("s2_wr");
    set_pkt(4'd2, 16'h0001, 32'h0, 1'b0, 1'b1, 4'h0, 16'h0, 1'b1);
    load_la();
    run_access("s2_rd");
    chk("s2_rd.word0", host.la_data0, 32'hA5A5_1234);

    set_pkt(4'd7, 16'h0003, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'hF, 16'h3, 1'b0);
    load_la();
    run_access("sel7");
    chk("sel7.la0", host.la_data0, 32'h0);
    chk("sel7.la1", host.la_data1, 32'h0);

    set_pkt(4'd3, 16'h0005, 32'h8000_0001, 1'b0, 1'b0, 4'hF, 16'h0, 1'b1);
    load_la();
    run_access("s3_wr");
    set_pkt(4'd3, 16'h0005, 32'h0, 1'b0, 1'b1, 4'h0, 16'h0, 1'b1);
    load_la();
    run_access("s3_rd");
    chk("s3_rd.word0", host.la_data0, 32'h8000_0001);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("scan%0d", i), host.gpio_data0, (i == 0 || i == 31));
      chk($sformatf("scan1_%0d", i), host.gpio_data1, 1'b0);
      host.gpio_out_scan = 1'b1;
      tick();
      host.gpio_out_scan = 1'b0;
    end
    chk("scan.end", host.gpio_data0, 1'b0);
    chk("scan.la0_kept", host.la_data0, 32'h8000_0001);

    set_pkt(4'd0, 16'h0001, 32'h0, 1'b0, 1'b1, 4'h0, 16'h0001, 1'b0);
    load_la();
    host.la_sram_load = 1'b1;
    tick();
    host.la_sram_load = 1'b0;
    chk("mid.active", c0[54], 1'b0);
    reset = 1'b1;
    tick();
    check_conns("mid.rst", 0);
    chk("mid.la0", host.la_data0, 32'h0);
    chk("mid.la1", host.la_data1, 32'h0);
    chk("mid.gp0", host.gpio_data0, 1'b0);
    reset = 1'b0;
    load_la();
    run_access("post_rst");
    chk("post_rst.word0", host.la_data0, 32'h1);

    for (int n = 0; n < 40; n++) begin
      f_sel  = 4'($urandom_range(0, 7));
      f_a0   = 16'($urandom) & 16'hFC07;
      f_din0 = $urandom;
      f_csb0 = ($urandom_range(0, 3) == 0);
      f_web0 = 1'($urandom);
      f_wm0  = 4'($urandom);
      f_a1   = 16'($urandom) & 16'hFC07;
      f_din1 = $urandom;
      f_csb1 = 1'($urandom);
      f_web1 = 1'($urandom);
      f_wm1  = 4'($urandom);
      if ($urandom_range(0, 1) == 1) load_gpio();
      else load_la();
      run_access($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
